uart_tx_scheduler: RTL and testbench

Shares one `uart_tx` transmitter between three byte sources: keyboard receive, board receive and the button/switch path. Each source has a small FIFO, so simultaneous or back-to-back events are queued instead of overwritten. A round-robin arbiter selects the next byte. A four-state FSM launches it on the transmitter and waits for the transmitter to finish. When a byte completes, the block emits an echo pulse carrying the byte, which feeds the seven-segment and VGA write paths.

---
 rtl/uart_tx_scheduler_if.sv | 29 ++
 rtl/uart_tx_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Signal bundle between the three byte sources, the shared uart_tx and the echo consumers.
// The slave view belongs to the scheduler; the master view drives sources and uart_tx status.
interface uart_tx_scheduler_if;
    logic [2:0] push_i;
    logic [7:0] src0_data_i;
    logic [7:0] src1_data_i;
    logic [7:0] src2_data_i;
    logic [2:0] full_o;
    logic [2:0] overflow_o;
    logic [7:0] tx_data_o;
    logic       tx_en_o;
    logic       tx_busy_i;
    logic [7:0] echo_data_o;
    logic [1:0] echo_src_o;
    logic       echo_valid_o;
    logic       timeout_err_o;

    modport master (
        output push_i, src0_data_i, src1_data_i, src2_data_i, tx_busy_i,
        input  full_o, overflow_o, tx_data_o, tx_en_o, echo_data_o, echo_src_o,
               echo_valid_o, timeout_err_o
    );

    modport slave (
        input  push_i, src0_data_i, src1_data_i, src2_data_i, tx_busy_i,
        output full_o, overflow_o, tx_data_o, tx_en_o, echo_data_o, echo_src_o,
               echo_valid_o, timeout_err_o
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between three queued byte sources using round-robin arbitration,
// launches each byte, waits for the frame to finish and echoes the completed byte.
module uart_tx_scheduler #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned START_TIMEOUT = 16
) (
    input logic                clk_i,
    input logic                rst_i,
    uart_tx_scheduler_if.slave bus_io
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWaitStart,
        StWaitDone
    } state_e;

    state_e          state_q;
    logic [1:0]      last_q;
    logic [7:0]      tx_data_q;
    logic            tx_en_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      echo_data_q;
    logic [1:0]      echo_src_q;
    logic            echo_valid_q;
    logic            timeout_q;
    logic [2:0]      overflow_q;

    logic [7:0]      mem_q  [3][FIFO_DEPTH];
    logic [PW-1:0]   wptr_q [3];
    logic [PW-1:0]   rptr_q [3];

    logic [7:0]      src_data [3];
    logic [2:0]      fifo_empty;
    logic [2:0]      fifo_full;
    logic [2:0]      push_ok;
    logic [2:0]      pop;
    logic            grant_valid;
    logic [1:0]      grant_idx;
    logic [1:0]      cand1;
    logic [1:0]      cand2;
    logic [7:0]      head_data;

    // (base + step) mod 3 for base in 0..2, step in 1..2
    function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    always_comb begin
        src_data[0] = bus_io.src0_data_i;
        src_data[1] = bus_io.src1_data_i;
        src_data[2] = bus_io.src2_data_i;
        for (int i = 0; i < 3; i++) begin
            fifo_empty[i] = (wptr_q[i] == rptr_q[i]);
            fifo_full[i]  = (wptr_q[i][PW-1] != rptr_q[i][PW-1]) &&
                            (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]);
            // Fullness is judged before any same-cycle pop, so a push to a full FIFO drops.
            push_ok[i]    = bus_io.push_i[i] & ~fifo_full[i];
        end
    end

    always_comb begin
        cand1       = rr_pick(last_q, 2'd1);
        cand2       = rr_pick(last_q, 2'd2);
        grant_valid = 1'b0;
        grant_idx   = last_q;
        if (state_q == StIdle) begin
            if (!fifo_empty[cand1]) begin
                grant_valid = 1'b1;
                grant_idx   = cand1;
            end else if (!fifo_empty[cand2]) begin
                grant_valid = 1'b1;
                grant_idx   = cand2;
            end else if (!fifo_empty[last_q]) begin
                grant_valid = 1'b1;
                grant_idx   = last_q;
            end
        end
        pop       = grant_valid ? (3'b001 << grant_idx) : 3'b000;
        head_data = mem_q[grant_idx][rptr_q[grant_idx][AW-1:0]];
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 3; i++) begin
            if (push_ok[i]) begin
                mem_q[i][wptr_q[i][AW-1:0]] <= src_data[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 3; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
            end
            overflow_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push_ok[i]) begin
                    wptr_q[i] <= wptr_q[i] + PW'(1);
                end
                if (pop[i]) begin
                    rptr_q[i] <= rptr_q[i] + PW'(1);
                end
                if (bus_io.push_i[i] && fifo_full[i]) begin
                    overflow_q[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            last_q       <= 2'd2;
            tx_data_q    <= '0;
            tx_en_q      <= 1'b0;
            cnt_q        <= '0;
            echo_data_q  <= '0;
            echo_src_q   <= '0;
            echo_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            tx_en_q      <= 1'b0;
            echo_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        tx_data_q <= head_data;
                        last_q    <= grant_idx;
                        tx_en_q   <= 1'b1;
                        state_q   <= StLaunch;
                    end
                end
                StLaunch: begin
                    cnt_q   <= '0;
                    state_q <= StWaitStart;
                end
                StWaitStart: begin
                    if (bus_io.tx_busy_i) begin
                        state_q <= StWaitDone;
                    end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
                        // Launch never acknowledged: drop the byte without an echo.
                        timeout_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StWaitDone: begin
                    if (!bus_io.tx_busy_i) begin
                        echo_data_q  <= tx_data_q;
                        echo_src_q   <= last_q;
                        echo_valid_q <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
            endcase
        end
    end

    assign bus_io.full_o        = fifo_full;
    assign bus_io.overflow_o    = overflow_q;
    assign bus_io.tx_data_o     = tx_data_q;
    assign bus_io.tx_en_o       = tx_en_q;
    assign bus_io.echo_data_o   = echo_data_q;
    assign bus_io.echo_src_o    = echo_src_q;
    assign bus_io.echo_valid_o  = echo_valid_q;
    assign bus_io.timeout_err_o = timeout_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: table vectors, directed corner sequences and
// randomized pushes compared against a queue-based model of the scheduler.
module tb_uart_tx_scheduler;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] src;
    } ev_t;

    typedef struct packed {
        logic [2:0]       mask;
        logic [2:0][7:0]  d;
        int               n;
        logic [2:0][7:0]  eb;
        logic [2:0][1:0]  es;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_tx_scheduler_if bus ();

    uart_tx_scheduler #(
        .FIFO_DEPTH    (DEPTH),
        .START_TIMEOUT (TMO)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // uart_tx stand-in: 0 = frame of busy_len cycles after tx_en, 1 = stuck low, 2 = stuck high
    int busy_mode = 0;
    int busy_len  = 10;
    int busy_left = 0;
    always @(negedge clk) begin
        if (rst) busy_left = 0;
        else if (bus.tx_en_o) busy_left = busy_len;
        else if (busy_left > 0) busy_left--;
        case (busy_mode)
            1:       bus.tx_busy_i = 1'b0;
            2:       bus.tx_busy_i = 1'b1;
            default: bus.tx_busy_i = (busy_left > 0);
        endcase
    end

    logic [7:0] tx_log[$];
    ev_t        echo_log[$];

    // Reference model: per-source queues, round-robin pointer, expected echo order
    bit         model_on = 1'b0;
    logic [7:0] mq [3][$];
    int         m_last = 2;
    bit [2:0]   m_ovf = '0;
    ev_t        m_exp_echo[$];
    logic [2:0] pend_push = '0;
    logic [7:0] pend_d [3];

    always @(posedge clk) begin
        pend_push = bus.push_i;
        pend_d[0] = bus.src0_data_i;
        pend_d[1] = bus.src1_data_i;
        pend_d[2] = bus.src2_data_i;
    end

    task automatic model_step();
        int  g;
        ev_t e;
        ev_t got;
        g = -1;
        if (bus.tx_en_o) begin
            for (int k = 1; k <= 3; k++) begin
                int c;
                c = (m_last + k) % 3;
                if (g < 0 && mq[c].size() > 0) g = c;
            end
            check("rand_grant_has_data", 32'(g >= 0), 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            if (pend_push[i]) begin
                if (mq[i].size() >= DEPTH) m_ovf[i] = 1'b1;
                else mq[i].push_back(pend_d[i]);
            end
        end
        if (g >= 0) begin
            e.data = mq[g].pop_front();
            e.src  = g[1:0];
            check("rand_tx_data", bus.tx_data_o, e.data);
            m_exp_echo.push_back(e);
            m_last = g;
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rand_full%0d", i), bus.full_o[i], 32'(mq[i].size() == DEPTH));
            check($sformatf("rand_ovf%0d", i), bus.overflow_o[i], m_ovf[i]);
        end
        if (bus.echo_valid_o) begin
            check("rand_echo_pending", 32'(m_exp_echo.size() > 0), 32'd1);
            if (m_exp_echo.size() > 0) begin
                e   = m_exp_echo.pop_front();
                got = '{data: bus.echo_data_o, src: bus.echo_src_o};
                check("rand_echo", got, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tx_en_o) tx_log.push_back(bus.tx_data_o);
            if (bus.echo_valid_o) echo_log.push_back('{data: bus.echo_data_o, src: bus.echo_src_o});
            if (model_on) model_step();
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push1(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c);
        bus.push_i      = m;
        bus.src0_data_i = a;
        bus.src1_data_i = b;
        bus.src2_data_i = c;
        step();
        bus.push_i = '0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.push_i = '0;
        busy_mode  = 0;
        busy_len   = 10;
        step(2);
        tx_log.delete();
        echo_log.delete();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_echo(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (echo_log.size() < n && c < budget) begin
            step();
            c++;
        end
        check({name, "_echo_count"}, echo_log.size(), n);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_full"}, bus.full_o, 3'b000);
        check({name, "_overflow"}, bus.overflow_o, 3'b000);
        check({name, "_tx_data"}, bus.tx_data_o, 8'h00);
        check({name, "_tx_en"}, bus.tx_en_o, 1'b0);
        check({name, "_echo_data"}, bus.echo_data_o, 8'h00);
        check({name, "_echo_src"}, bus.echo_src_o, 2'd0);
        check({name, "_echo_valid"}, bus.echo_valid_o, 1'b0);
        check({name, "_timeout"}, bus.timeout_err_o, 1'b0);
    endtask

    task automatic check_seq(input string name, input logic [7:0] eb[$], input logic [1:0] es[$]);
        step(5);
        check({name, "_tx_count"}, tx_log.size(), eb.size());
        for (int j = 0; j < eb.size(); j++) begin
            if (j < tx_log.size()) check($sformatf("%s_tx%0d", name, j), tx_log[j], eb[j]);
            if (j < echo_log.size()) begin
                check($sformatf("%s_echo_data%0d", name, j), echo_log[j].data, eb[j]);
                check($sformatf("%s_echo_src%0d", name, j), echo_log[j].src, es[j]);
            end
        end
    endtask

    vec_t vecs[6];

    initial begin
        logic [7:0] eb[$];
        logic [1:0] es[$];

        vecs[0] = '{mask: 3'b001, d: {8'h00, 8'h00, 8'h41}, n: 1,
                    eb: {8'h00, 8'h00, 8'h41}, es: {2'd0, 2'd0, 2'd0}};
        vecs[1] = '{mask: 3'b111, d: {8'hC2, 8'hB1, 8'hA0}, n: 3,
                    eb: {8'hC2, 8'hB1, 8'hA0}, es: {2'd2, 2'd1, 2'd0}};
        vecs[2] = '{mask: 3'b110, d: {8'h22, 8'h11, 8'h00}, n: 2,
                    eb: {8'h00, 8'h22, 8'h11}, es: {2'd0, 2'd2, 2'd1}};
        vecs[3] = '{mask: 3'b101, d: {8'h44, 8'h00, 8'h33}, n: 2,
                    eb: {8'h00, 8'h44, 8'h33}, es: {2'd0, 2'd2, 2'd0}};
        vecs[4] = '{mask: 3'b100, d: {8'h5A, 8'h00, 8'h00}, n: 1,
                    eb: {8'h00, 8'h00, 8'h5A}, es: {2'd0, 2'd0, 2'd2}};
        vecs[5] = '{mask: 3'b011, d: {8'h00, 8'h88, 8'h77}, n: 2,
                    eb: {8'h00, 8'h88, 8'h77}, es: {2'd0, 2'd1, 2'd0}};

        bus.push_i      = '0;
        bus.src0_data_i = '0;
        bus.src1_data_i = '0;
        bus.src2_data_i = '0;
        step(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Single byte with exact launch and completion timing
        do_reset();
        push1(3'b001, 8'h41, 8'h00, 8'h00);
        check("lat_n1_tx_en", bus.tx_en_o, 1'b0);
        step();
        check("lat_n2_tx_en", bus.tx_en_o, 1'b1);
        check("lat_n2_tx_data", bus.tx_data_o, 8'h41);
        step();
        check("lat_n3_tx_en", bus.tx_en_o, 1'b0);
        check("lat_hold_tx_data", bus.tx_data_o, 8'h41);
        step(9);
        check("done_early_echo", bus.echo_valid_o, 1'b0);
        step();
        check("done_echo_valid", bus.echo_valid_o, 1'b1);
        check("done_echo_data", bus.echo_data_o, 8'h41);
        check("done_echo_src", bus.echo_src_o, 2'd0);
        step();
        check("done_echo_pulse", bus.echo_valid_o, 1'b0);
        step(10);
        check("single_tx_count", tx_log.size(), 1);

        // Table: simultaneous push patterns from reset
        for (int v = 0; v < 6; v++) begin
            do_reset();
            push1(vecs[v].mask, vecs[v].d[0], vecs[v].d[1], vecs[v].d[2]);
            wait_echo(vecs[v].n, 200, $sformatf("vec%0d", v));
            eb.delete();
            es.delete();
            for (int j = 0; j < vecs[v].n; j++) begin
                eb.push_back(vecs[v].eb[j]);
                es.push_back(vecs[v].es[j]);
            end
            check_seq($sformatf("vec%0d", v), eb, es);
        end

        // Overflow: FSM parked in WAIT_DONE, source 1 overfilled
        do_reset();
        busy_mode = 2;
        push1(3'b001, 8'hEE, 8'h00, 8'h00);
        step(3);
        for (int k = 0; k < 5; k++) begin
            push1(3'b010, 8'h00, 8'(8'h10 + k), 8'h00);
            check($sformatf("ovf_full_after%0d", k + 1), bus.full_o[1], 32'(k >= 3));
            check($sformatf("ovf_flag_after%0d", k + 1), bus.overflow_o[1], 32'(k == 4));
        end
        busy_mode = 0;
        wait_echo(5, 300, "ovf");
        eb = '{8'hEE, 8'h10, 8'h11, 8'h12, 8'h13};
        es = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
        check_seq("ovf", eb, es);
        check("ovf_sticky", bus.overflow_o, 3'b010);
        check("ovf_drained_full", bus.full_o, 3'b000);

        // Timeout: busy never rises
        do_reset();
        busy_mode = 1;
        push1(3'b001, 8'h55, 8'h00, 8'h00);
        step(17);
        check("tmo_not_yet", bus.timeout_err_o, 1'b0);
        step();
        check("tmo_set", bus.timeout_err_o, 1'b1);
        check("tmo_no_echo", echo_log.size(), 0);
        busy_mode = 0;
        push1(3'b001, 8'h66, 8'h00, 8'h00);
        wait_echo(1, 200, "tmo_recover");
        if (echo_log.size() > 0) begin
            check("tmo_recover_data", echo_log[0].data, 8'h66);
            check("tmo_recover_src", echo_log[0].src, 2'd0);
        end
        check("tmo_recover_tx_count", tx_log.size(), 2);
        check("tmo_sticky", bus.timeout_err_o, 1'b1);

        // Fairness with sources 0 and 2 loaded, 1 empty
        do_reset();
        push1(3'b101, 8'h01, 8'h00, 8'h81);
        push1(3'b101, 8'h02, 8'h00, 8'h82);
        push1(3'b101, 8'h03, 8'h00, 8'h83);
        wait_echo(6, 400, "rr");
        eb = '{8'h01, 8'h81, 8'h02, 8'h82, 8'h03, 8'h83};
        es = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
        check_seq("rr", eb, es);

        // Reset in WAIT_DONE with two bytes queued
        do_reset();
        busy_mode = 2;
        push1(3'b001, 8'h91, 8'h00, 8'h00);
        push1(3'b001, 8'h92, 8'h00, 8'h00);
        push1(3'b001, 8'h93, 8'h00, 8'h00);
        step(3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        busy_mode = 0;
        tx_log.delete();
        echo_log.delete();
        rst = 1'b0;
        step(40);
        check("midrst_no_tx", tx_log.size(), 0);
        check("midrst_no_echo", echo_log.size(), 0);

        // Reset during LAUNCH drops tx_en at once
        push1(3'b001, 8'hA5, 8'h00, 8'h00);
        step();
        check("launch_tx_en", bus.tx_en_o, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("launch_rst_tx_en", bus.tx_en_o, 1'b0);
        step();

        // Randomized traffic against the model
        do_reset();
        busy_len = 3;
        for (int i = 0; i < 3; i++) mq[i].delete();
        m_exp_echo.delete();
        m_last   = 2;
        m_ovf    = '0;
        model_on = 1'b1;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            int rate;
            rate = (cyc < 500) ? 9 : ((cyc < 1000) ? 30 : 1000000);
            bus.push_i[0]   = ($urandom_range(0, rate) == 0);
            bus.push_i[1]   = ($urandom_range(0, rate) == 0);
            bus.push_i[2]   = ($urandom_range(0, rate) == 0);
            bus.src0_data_i = 8'($urandom);
            bus.src1_data_i = 8'($urandom);
            bus.src2_data_i = 8'($urandom);
            step();
        end
        bus.push_i = '0;
        step(100);
        model_on = 1'b0;
        check("rand_all_echoed", m_exp_echo.size(), 0);
        check("rand_tx_vs_echo", tx_log.size(), echo_log.size());
        check("rand_final_full", bus.full_o, 3'b000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
